// File: rtl/rx_serial_uart_param.sv
// Parameterised asynchronous serial receiver: 5..9 data bits, optional odd/even parity,
// 1 or 2 stop bits, with framing/parity error flags and a sticky overrun flag.
module rx_serial_uart_param #(
  parameter int unsigned CLK_PER_BIT = 434,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RX,
  input  logic                 limpa,
  output logic [DATA_BITS-1:0] dados,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_parada,
  output logic                 sobreposicao,
  output logic                 recebendo
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF      = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] LAST      = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  localparam logic [2:0] INICIAL  = 3'd0;
  localparam logic [2:0] PARTIDA  = 3'd1;
  localparam logic [2:0] DADOS    = 3'd2;
  localparam logic [2:0] PARIDADE = 3'd3;
  localparam logic [2:0] PARADA   = 3'd4;
  localparam logic [2:0] ARMAZENA = 3'd5;
  localparam logic [2:0] ESPERA   = 3'd6;

  logic [1:0]           sync_q;
  logic                 rs;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 store;
  logic                 tick;

  assign rs        = sync_q[1];
  assign tick      = (cnt_q == LAST);
  assign recebendo = (state_q != INICIAL);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    store      = 1'b0;
    case (state_q)
      INICIAL: begin
        if (!rs) begin
          cnt_d   = '0;
          state_d = PARTIDA;
        end
      end
      PARTIDA: begin
        if (cnt_q == HALF) begin
          cnt_d      = '0;
          bit_d      = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
          state_d    = rs ? INICIAL : DADOS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DADOS: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rs, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PARIDADE : PARADA;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARIDADE: begin
        if (tick) begin
          cnt_d     = '0;
          // Odd parity expects the XOR over data and parity bit to be 1, even expects 0.
          par_err_d = ((^shift_q) ^ rs) != ODD;
          state_d   = PARADA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARADA: begin
        if (tick) begin
          cnt_d = '0;
          if (!rs) stop_err_d = 1'b1;
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = ARMAZENA;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARMAZENA: begin
        store   = 1'b1;
        // A low line after a bad stop bit is a break, not a new start.
        state_d = stop_err_q ? ESPERA : INICIAL;
      end
      ESPERA: begin
        if (rs) state_d = INICIAL;
      end
      default: state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b11;
      state_q    <= INICIAL;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dados         <= '0;
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
      sobreposicao  <= 1'b0;
    end else if (store) begin
      dados         <= shift_q;
      pronto        <= 1'b1;
      erro_paridade <= par_err_q;
      erro_parada   <= stop_err_q;
      // A simultaneous acknowledge consumes the old word, so no overrun is flagged.
      sobreposicao  <= (pronto | sobreposicao) & ~limpa;
    end else if (limpa && pronto) begin
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
      sobreposicao  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_serial_uart_param.sv
// Bench for rx_serial_uart_param: three instances (8N1, 8E1, 7N2) driven with directed
// and random frames, checked against a frame-level model of what each word should report.
module tb_rx_serial_uart_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] limpa;
  wire  [7:0] d0, d1;
  wire  [6:0] d2;
  wire  [2:0] pr, pe, se, sob, rec;

  int vectors     = 0;
  int miscompares = 0;
  int rise0       = 0;
  logic pr0_prev  = 1'b0;

  // Model state per instance
  logic exp_pronto [3];
  logic exp_sob    [3];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pr0_prev <= pr[0];
    if (pr[0] && !pr0_prev) rise0 <= rise0 + 1;
  end

  rx_serial_uart_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clk), .reset(rst), .RX(rx[0]), .limpa(limpa[0]), .dados(d0), .pronto(pr[0]),
    .erro_paridade(pe[0]), .erro_parada(se[0]), .sobreposicao(sob[0]), .recebendo(rec[0])
  );

  rx_serial_uart_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clock(clk), .reset(rst), .RX(rx[1]), .limpa(limpa[1]), .dados(d1), .pronto(pr[1]),
    .erro_paridade(pe[1]), .erro_parada(se[1]), .sobreposicao(sob[1]), .recebendo(rec[1])
  );

  rx_serial_uart_param #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clock(clk), .reset(rst), .RX(rx[2]), .limpa(limpa[2]), .dados(d2), .pronto(pr[2]),
    .erro_paridade(pe[2]), .erro_parada(se[2]), .sobreposicao(sob[2]), .recebendo(rec[2])
  );

  function automatic logic [31:0] get_dados(input int w);
    case (w)
      0:       return {24'd0, d0};
      1:       return {24'd0, d1};
      default: return {25'd0, d2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input int w, input logic b);
    rx[w] = b;
    cycles(CPB);
  endtask

  // Drives a full frame; RX is left at the last stop-bit level.
  task automatic send(input int w, input logic [8:0] data, input logic pbit,
                      input logic [1:0] stops);
    int nb    = (w == 2) ? 7 : 8;
    int nstop = (w == 2) ? 2 : 1;
    bit_time(w, 1'b0);
    for (int i = 0; i < nb; i++) bit_time(w, data[i]);
    if (w == 1) bit_time(w, pbit);
    for (int i = 0; i < nstop; i++) bit_time(w, stops[i]);
  endtask

  task automatic pulse_limpa(input int w);
    limpa[w] = 1'b1;
    cycles(1);
    limpa[w] = 1'b0;
    cycles(1);
    exp_pronto[w] = 1'b0;
    exp_sob[w]    = 1'b0;
  endtask

  task automatic wait_pronto(input int w);
    int n = 0;
    while (!pr[w] && n < 64) begin
      cycles(1);
      n++;
    end
    check("pronto_wait", {31'd0, pr[w]}, 32'd1);
  endtask

  // Frame-level expectation: what a word sent with these bits must report.
  task automatic expect_word(input string tag, input int w, input logic [8:0] data,
                             input logic pbit, input logic [1:0] stops);
    int   nb    = (w == 2) ? 7 : 8;
    int   nstop = (w == 2) ? 2 : 1;
    logic [31:0] word = {23'd0, data} & ((32'd1 << nb) - 1);
    logic exp_pe = (w == 1) && (($countones({word, pbit}) % 2) != 0);
    logic exp_se = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    exp_sob[w]    = exp_sob[w] | exp_pronto[w];
    exp_pronto[w] = 1'b1;
    check({tag, "_dados"}, get_dados(w), word);
    check({tag, "_pronto"}, {31'd0, pr[w]}, 32'd1);
    check({tag, "_erro_paridade"}, {31'd0, pe[w]}, {31'd0, exp_pe});
    check({tag, "_erro_parada"}, {31'd0, se[w]}, {31'd0, exp_se});
    check({tag, "_sobreposicao"}, {31'd0, sob[w]}, {31'd0, exp_sob[w]});
  endtask

  initial begin
    int snap;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;

    rst   = 1'b1;
    rx    = 3'b111;
    limpa = 3'b000;
    for (int w = 0; w < 3; w++) begin
      exp_pronto[w] = 1'b0;
      exp_sob[w]    = 1'b0;
    end
    cycles(3);
    check("reset_pronto", {29'd0, pr}, 32'd0);
    check("reset_recebendo", {29'd0, rec}, 32'd0);
    check("reset_flags", {23'd0, pe, se, sob}, 32'd0);
    check("reset_dados", {9'd0, d0, d1, d2}, 32'd0);
    rst = 1'b0;
    cycles(4);

    // Ideal 8N1 frame, word held until acknowledged
    send(0, 9'h055, 1'b0, 2'b11);
    rx[0] = 1'b1;
    wait_pronto(0);
    cycles(4);
    expect_word("t1", 0, 9'h055, 1'b0, 2'b11);
    check("t1_recebendo", {31'd0, rec[0]}, 32'd0);
    cycles(3 * CPB);
    check("t1_pronto_held", {31'd0, pr[0]}, 32'd1);
    pulse_limpa(0);
    check("t1_pronto_cleared", {31'd0, pr[0]}, 32'd0);

    // Even parity: 0xA3 with a wrong then a correct parity bit
    send(1, 9'h0A3, 1'b1, 2'b11);
    rx[1] = 1'b1;
    wait_pronto(1);
    cycles(4);
    expect_word("t2a", 1, 9'h0A3, 1'b1, 2'b11);
    pulse_limpa(1);
    send(1, 9'h0A3, 1'b0, 2'b11);
    rx[1] = 1'b1;
    wait_pronto(1);
    cycles(4);
    expect_word("t2b", 1, 9'h0A3, 1'b0, 2'b11);
    pulse_limpa(1);

    // Framing error followed by a line break
    snap = rise0;
    send(0, 9'h000, 1'b0, 2'b00);
    cycles(3 * CPB);
    expect_word("t3", 0, 9'h000, 1'b0, 2'b00);
    check("t3_recebendo_break", {31'd0, rec[0]}, 32'd1);
    check("t3_single_pronto", rise0 - snap, 32'd1);
    rx[0] = 1'b1;
    cycles(6);
    check("t3_recebendo_idle", {31'd0, rec[0]}, 32'd0);
    pulse_limpa(0);

    // False start
    rx[0] = 1'b0;
    cycles(4);
    check("t4_recebendo_start", {31'd0, rec[0]}, 32'd1);
    rx[0] = 1'b1;
    cycles(CPB + 4);
    check("t4_recebendo_idle", {31'd0, rec[0]}, 32'd0);
    check("t4_pronto", {31'd0, pr[0]}, 32'd0);

    // Overrun
    send(0, 9'h012, 1'b0, 2'b11);
    bit_time(0, 1'b1);
    expect_word("t5a", 0, 9'h012, 1'b0, 2'b11);
    send(0, 9'h034, 1'b0, 2'b11);
    bit_time(0, 1'b1);
    expect_word("t5b", 0, 9'h034, 1'b0, 2'b11);
    pulse_limpa(0);
    check("t5_pronto_cleared", {31'd0, pr[0]}, 32'd0);
    check("t5_sob_cleared", {31'd0, sob[0]}, 32'd0);

    // Random frames on every configuration, acknowledging only some words
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 6; k++) begin
        data  = 9'($urandom);
        pbit  = 1'($urandom);
        stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        send(w, data, pbit, stops);
        bit_time(w, 1'b1);
        expect_word("rand", w, data, pbit, stops);
        if ($urandom_range(0, 1) == 1) begin
          pulse_limpa(w);
          check("rand_pronto_cleared", {31'd0, pr[w]}, 32'd0);
        end
      end
      pulse_limpa(w);
    end

    // Reset during data bit 3 of a 7N2 frame, then a clean frame
    bit_time(2, 1'b0);
    for (int i = 0; i < 3; i++) bit_time(2, 1'b1);
    rx[2] = 1'b0;
    cycles(5);
    rst = 1'b1;
    cycles(3);
    check("t6_reset_pronto", {29'd0, pr}, 32'd0);
    check("t6_reset_recebendo", {29'd0, rec}, 32'd0);
    check("t6_reset_flags", {29'd0, pe | se | sob}, 32'd0);
    check("t6_reset_dados", {25'd0, d2}, 32'd0);
    rx[2] = 1'b1;
    rst   = 1'b0;
    for (int w = 0; w < 3; w++) begin
      exp_pronto[w] = 1'b0;
      exp_sob[w]    = 1'b0;
    end
    cycles(2 * CPB);
    send(2, 9'h03C, 1'b0, 2'b11);
    rx[2] = 1'b1;
    wait_pronto(2);
    cycles(4);
    expect_word("t6", 2, 9'h03C, 1'b0, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
